// File: rtl/load_store_unit.sv
// load_store_unit: memory-access unit between the core's execute sequencing
// and a valid/ack memory bus. Each access is sent as a lane-aligned bus beat
// with byte strobes. The unit supports bus wait states and a bus timeout, and
// it sign- or zero-extends load data.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN. When it is defined, an
// access that crosses a lane boundary runs as two consecutive beats. When it
// is undefined, such an access returns an error.
module load_store_unit #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN/8-1:0]   bus_wstrb,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic                bus_ack,
    input  logic [XLEN-1:0]     bus_rdata
);

    localparam int NB     = XLEN / 8;
    localparam int OFS_W  = $clog2(NB);
    localparam int WAIT_W = 16;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, signed_q, err_q;
    logic [1:0]          size_q;
    logic [3:0]          bytes_q;
    logic [OFS_W-1:0]    ofs_q;
    logic [XLEN-1:0]     beat0_q, beat1_q;
    logic [WAIT_W-1:0]   wait_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic                split_q;
    logic [ADDR_W-1:0]   base_q;
    logic [XLEN-1:0]     wdata_q;
`endif

    logic                accept, bad_size, crossing, beat_done, timeout;
    logic [3:0]          req_bytes;
    logic [OFS_W-1:0]    req_ofs;
    logic [XLEN-1:0]     load_sh, load_mask, load_ext;
    logic                load_sign;

    // Byte-lane enables for an access, over two beats' worth of lanes.
    function automatic logic [2*NB-1:0] lane_strb(input logic [OFS_W-1:0] ofs,
                                                  input logic [3:0] bytes);
        return (((2*NB)'(1) << bytes) - (2*NB)'(1)) << ofs;
    endfunction

    // Write data shifted into lane position, over two beats' worth of lanes.
    function automatic logic [2*XLEN-1:0] lane_data(input logic [XLEN-1:0] wdata,
                                                    input logic [OFS_W-1:0] ofs);
        return {{XLEN{1'b0}}, wdata} << {ofs, 3'b000};
    endfunction

    // Request decode and beat-completion conditions.
    always_comb begin
        req_bytes = 4'd1 << req_size;
        req_ofs   = req_addr[OFS_W-1:0];
        accept    = req_valid && req_ready;
        bad_size  = (req_size == 2'd3) && (XLEN == 32);
        crossing  = (int'(req_ofs) + int'(req_bytes)) > NB;
        beat_done = bus_req && bus_ack;
        timeout   = bus_req && !bus_ack && (wait_q == WAIT_W'(MAX_WAIT - 1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: the default comes first, so every path assigns state_d and
        // no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad_size) begin
                        state_d = RESP;
                    end else if (crossing) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                        state_d = BEAT0;
`else
                        state_d = RESP;
`endif
                    end else begin
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (beat_done) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    state_d = split_q ? BEAT1 : RESP;
`else
                    state_d = RESP;
`endif
                end else if (timeout) begin
                    state_d = RESP;
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            BEAT1: begin
                if (beat_done || timeout) state_d = RESP;
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, bus beat registers, read capture and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= 2'd0;
            bytes_q   <= 4'd0;
            ofs_q     <= '0;
            beat0_q   <= '0;
            beat1_q   <= '0;
            wait_q    <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q   <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q     <= req_we;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        bytes_q  <= req_bytes;
                        ofs_q    <= req_ofs;
                        beat0_q  <= '0;
                        beat1_q  <= '0;
                        wait_q   <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                        split_q  <= crossing;
                        base_q   <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                        wdata_q  <= req_wdata;
                        err_q    <= bad_size;
                        if (!bad_size) begin
`else
                        err_q    <= bad_size || crossing;
                        if (!bad_size && !crossing) begin
`endif
                            bus_req   <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                            bus_wstrb <= NB'(lane_strb(req_ofs, req_bytes));
                            bus_wdata <= XLEN'(lane_data(req_wdata, req_ofs));
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (beat_done) begin
                        wait_q <= '0;
                        if (state_q == BEAT0) beat0_q <= bus_rdata;
                        else                  beat1_q <= bus_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
                        if (state_q == BEAT0 && split_q) begin
                            // Second beat: the next lane-aligned word, low lanes.
                            bus_addr  <= base_q + ADDR_W'(NB);
                            bus_wstrb <= NB'(lane_strb(ofs_q, bytes_q) >> NB);
                            bus_wdata <= XLEN'(lane_data(wdata_q, ofs_q) >> XLEN);
                        end else begin
                            bus_req   <= 1'b0;
                            bus_wstrb <= '0;
                        end
`else
                        bus_req   <= 1'b0;
                        bus_wstrb <= '0;
`endif
                    end else if (timeout) begin
                        bus_req   <= 1'b0;
                        bus_wstrb <= '0;
                        err_q     <= 1'b1;
                    end else if (bus_req) begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Load data alignment and sign/zero extension from the captured beats.
    always_comb begin
        load_sh   = XLEN'({beat1_q, beat0_q} >> {ofs_q, 3'b000});
        load_mask = ~({XLEN{1'b1}} << {bytes_q, 3'b000});
        case (size_q)
            2'd0:    load_sign = load_sh[7];
            2'd1:    load_sign = load_sh[15];
            2'd2:    load_sign = load_sh[31];
            default: load_sign = load_sh[XLEN-1];
        endcase
        load_ext = load_sh & load_mask;
        if (signed_q && load_sign) load_ext = load_ext | ~load_mask;
    end

    // Core-side handshake and response outputs.
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_ext : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test of load_store_unit with XLEN=32 and
// MAX_WAIT=4. The bench plays the role of the bus slave and checks the beat
// contents, the response data and the response latency. When
// LSU_MISALIGNED_SPLIT_EN is defined, a crossing load is expected to split
// into two beats; otherwise it is expected to return an error.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and let it be accepted at the next edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        check("req_ready_before_issue", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    // Serve one bus beat after a number of wait states; check its contents.
    task automatic beat(input string tag, input int waits, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic exp_we);
        for (int i = 0; i < waits; i++) begin
            check({tag, "_req_wait"}, bus_req, 1'b1);
            step();
        end
        check({tag, "_req"}, bus_req, 1'b1);
        check({tag, "_addr"}, bus_addr, exp_addr);
        check({tag, "_strb"}, bus_wstrb, exp_strb);
        check({tag, "_we"}, bus_we, exp_we);
        if (exp_we) check({tag, "_wdata"}, bus_wdata, exp_wdata);
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        step();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
    endtask

    // Wait (bounded) for the response pulse, then check data, error and latency.
    task automatic expect_rsp(input string tag, input logic [31:0] exp_data,
                              input logic exp_err, input int exp_lat);
        int budget;
        budget = 20;
        while (!rsp_valid && budget > 0) begin
            step();
            budget--;
        end
        if (!rsp_valid) begin
            check({tag, "_rsp_timeout"}, 1'b0, 1'b1);
        end else begin
            check({tag, "_rdata"}, rsp_rdata, exp_data);
            check({tag, "_err"}, rsp_err, exp_err);
            check({tag, "_latency"}, 64'(cyc - acc_cyc + 1), 64'(exp_lat));
            check({tag, "_bus_idle"}, bus_req, 1'b0);
            check({tag, "_ready_low"}, req_ready, 1'b0);
            step();
            check({tag, "_pulse_len"}, rsp_valid, 1'b0);
            check({tag, "_ready_back"}, req_ready, 1'b1);
        end
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        bus_ack    = 1'b0;
        bus_rdata  = 32'h0;
        step();
        step();

        // Reset values.
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wstrb", bus_wstrb, 4'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        rst = 1'b1;
        step();

        // An acknowledge while no beat is active is ignored.
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("stray_ack_rsp", rsp_valid, 1'b0);
        check("stray_ack_ready", req_ready, 1'b1);

        // Aligned word load, no wait states.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
        beat("lw", 0, 32'hDEAD_BEEF, 32'h0000_0100, 4'hF, 32'h0, 1'b0);
        expect_rsp("lw", 32'hDEAD_BEEF, 1'b0, 2);

        // Signed byte load from lane 3 with 3 wait states.
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0);
        beat("lb", 3, 32'h8000_0000, 32'h0000_0100, 4'h8, 32'h0, 1'b0);
        expect_rsp("lb", 32'hFFFF_FF80, 1'b0, 5);

        // The same access, zero-extended.
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0);
        beat("lbu", 3, 32'h8000_0000, 32'h0000_0100, 4'h8, 32'h0, 1'b0);
        expect_rsp("lbu", 32'h0000_0080, 1'b0, 5);

        // Signed half load from the upper lanes.
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0);
        beat("lh", 0, 32'h8001_0000, 32'h0000_0000, 4'hC, 32'h0, 1'b0);
        expect_rsp("lh", 32'hFFFF_8001, 1'b0, 2);

        // Misaligned half that stays inside one word: single beat.
        issue(1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0);
        beat("lhu_mid", 1, 32'h00AB_CD00, 32'h0000_0100, 4'h6, 32'h0, 1'b0);
        expect_rsp("lhu_mid", 32'h0000_ABCD, 1'b0, 3);

        // Half store; the response data is 0 even though the bus returns data.
        issue(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD);
        beat("sh", 0, 32'h1234_5678, 32'h0000_0200, 4'hC, 32'hABCD_0000, 1'b1);
        expect_rsp("sh", 32'h0, 1'b0, 2);

        // Word load that crosses a lane boundary, at the top of the address space.
        issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        beat("split_b0", 0, 32'h1122_0000, 32'hFFFF_FFFC, 4'hC, 32'h0, 1'b0);
        beat("split_b1", 0, 32'h0000_4433, 32'h0000_0000, 4'h3, 32'h0, 1'b0);
        expect_rsp("split", 32'h4433_1122, 1'b0, 3);
`else
        check("cross_no_bus", bus_req, 1'b0);
        expect_rsp("cross", 32'h0, 1'b1, 1);
`endif

        // Bus timeout: bus_req is high for MAX_WAIT cycles, then an error.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("tmo_req_high", bus_req, 1'b1);
            step();
        end
        expect_rsp("tmo", 32'h0, 1'b1, 5);

        // Double-word size on a 32-bit unit is an immediate error.
        issue(1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0);
        check("dword_no_bus", bus_req, 1'b0);
        expect_rsp("dword", 32'h0, 1'b1, 1);

        // Reset during the second wait cycle of a load.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0030, 32'h0);
        step();
        check("mid_rst_req_before", bus_req, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_bus_req", bus_req, 1'b0);
        check("mid_rst_ready", req_ready, 1'b1);
        check("mid_rst_rsp", rsp_valid, 1'b0);
        step();
        rst = 1'b1;
        step();

        // A normal load after reset release.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0);
        beat("post_rst", 1, 32'hCAFE_F00D, 32'h0000_0040, 4'hF, 32'h0, 1'b0);
        expect_rsp("post_rst", 32'hCAFE_F00D, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised memory-access unit between the multi-cycle core's execute sequencing and the external memory bus. It replaces the fixed one-cycle 32-bit `mem_size`/`mem_rw` path and the stand-alone sign extender. It adds:
- a valid/ready request handshake with wait-state support on the bus;
- byte-lane strobes;
- optional splitting of misaligned accesses;
- a bus-timeout error.

The core issues one request, stalls its T-counter until `rsp_valid`, then writes `rsp_rdata` to `rd` for loads.

## Interface
- `XLEN`, 32: data width, 32 or 64; `NB = XLEN/8` byte lanes, `OFS_W = log2(NB)`.
- `ADDR_W`, 32: address width.
- `MAX_WAIT`, 255: maximum cycles `bus_req` may stay high without `bus_ack` before the access aborts (1..2^16-1).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  unit idle, request accepted when `req_valid && req_ready` at a rising edge.
- `req_we`  in  1  0=load, 1=store.
- `req_size`  in  2  0=byte, 1=half, 2=word, 3=dword (legal only when XLEN=64).
- `req_signed`  in  1  sign-extend load result (0 = zero-extend).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  XLEN  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  valid with `rsp_valid`: illegal size, misaligned (split disabled), or timeout.
- `bus_req`  out  1  bus beat active, held until acknowledged.
- `bus_we`  out  1  beat is a write.
- `bus_addr`  out  ADDR_W  lane-aligned address (low OFS_W bits always 0).
- `bus_wstrb`  out  NB  byte-lane enables.
- `bus_wdata`  out  XLEN  lane-positioned write data.
- `bus_ack`  in  1  beat complete; read data valid on `bus_rdata` in the same cycle.
- `bus_rdata`  in  XLEN  lane-positioned read data.

## Operation
FSM states:
- **IDLE**: `req_ready=1`.
  - On accept, latch all `req_*` inputs and compute `bytes = 1<<req_size`, `ofs = req_addr[OFS_W-1:0]`.
  - `req_size==3` with XLEN=32 goes to RESP with err.
  - `ofs+bytes > NB` (crossing) goes to BEAT0 with `split=1` if splitting is enabled, otherwise to RESP with err.
  - All other requests go to BEAT0 with `split=0`.
- **BEAT0**:
  - `bus_addr = {addr[ADDR_W-1:OFS_W], 0}`.
  - `bus_wstrb = ((1<<bytes)-1) << ofs`, truncated to NB bits.
  - `bus_wdata = wdata << 8*ofs`.
  - On `bus_ack`, capture `bus_rdata`, then go to BEAT1 if split, else RESP.
- **BEAT1**:
  - `bus_addr` = BEAT0 address + NB, wrapping modulo 2^ADDR_W.
  - `bus_wstrb` = the remaining `ofs+bytes-NB` low lanes.
  - `bus_wdata = wdata >> 8*(NB-ofs)`.
  - On `bus_ack`, capture and go to RESP.
- **RESP**:
  - `rsp_valid=1` for exactly one cycle, then back to IDLE.
  - Load data: `{beat1,beat0} >> 8*ofs`, truncated to `bytes`, then sign- or zero-extended to XLEN.

Timeout and bus rules:
- A wait counter is cleared at the start of each beat and increments every cycle `bus_req` is high without `bus_ack`.
- If the counter reaches MAX_WAIT, `bus_req` drops at the next edge and the FSM goes to RESP with `rsp_err=1` and `rsp_rdata=0`. A BEAT0 write already acked is not rolled back.
- `bus_req`, `bus_we`, `bus_addr`, `bus_wstrb` and `bus_wdata` are registered and stable for the whole beat.
- `bus_ack` while `bus_req` is low is ignored.

Reset and errors:
- `rst` low at any time, including mid-beat, immediately forces IDLE and clears the counter and all registers.
- Error responses for illegal size or misalignment make no bus activity.

## Timing
Reset values:
- `req_ready=1`.
- `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`.
- `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_wstrb=0`, `bus_wdata=0`.

Edge numbering below uses edge 0 as the accept edge.

Aligned access with zero wait:
- Accept at edge 0.
- `bus_req` high during cycle 1; ack sampled at edge 1.
- `rsp_valid` high during cycle 2; `req_ready` high again from edge 2.
- Total latency 2 cycles, plus 1 per wait state, plus (split) 1 + waits of BEAT1.

Error paths:
- Immediate error: `rsp_valid` in cycle 1.
- Timeout: `rsp_valid` exactly MAX_WAIT+1 cycles after `bus_req` rose.

`req_ready=0` from accept until the RESP cycle ends, so back-to-back requests are spaced at least 2 cycles apart.

## Configuration
`LSU_MISALIGNED_SPLIT_EN`:
- Defined: lane-crossing accesses execute as two consecutive beats, BEAT0 at the lower aligned address.
- Undefined: BEAT1 logic is not compiled in. Crossing accesses return `rsp_err=1`, `rsp_rdata=0` one cycle after accept, with `bus_req` never asserted.

## Test plan
- XLEN=32, load word at 0x100, `bus_rdata=0xDEADBEEF`, ack in first cycle → `bus_wstrb=0xF`, `rsp_rdata=0xDEADBEEF`, `rsp_valid` 2 cycles after accept.
- Signed byte load at 0x103, `bus_rdata=0x80000000`, 3 wait states → `bus_addr=0x100`, `rsp_rdata=0xFFFFFF80`, latency 5. Same access unsigned → `0x00000080`.
- Store half 0xABCD to 0x202 → `bus_wstrb=0xC`, `bus_wdata=0xABCD0000`, `bus_we=1`, `rsp_rdata=0`.
- Split enabled, load word at 0xFFFFFFFE with beats returning 0x11220000 then 0x00004433 → beats at 0xFFFFFFFC then 0x00000000 (wrap), `rsp_rdata=0x44331122`. Split disabled → `rsp_err=1`, no `bus_req`.
- MAX_WAIT=4, `bus_ack` held low → `bus_req` high 4 cycles then low, `rsp_err=1`. XLEN=32 with `req_size=3` → immediate `rsp_err`.
- Assert `rst` low in the second wait cycle of a load → `bus_req` low immediately and `req_ready=1`. After release, a new load completes normally.
